// File: rtl/team_06_delay_line_ctrl.sv
// Circular delay-line controller: on each sample tick, read the sample stored
// `offset` ticks ago from byte memory, then write the new sample into the ring.
// Optional macro TEAM_06_FILL_GUARD_EN returns silence until enough history exists.
module team_06_delay_line_ctrl #(
  parameter int unsigned       ADDR_W    = 13,
  parameter int unsigned       MEM_AW    = 32,
  parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [7:0]        save_audio,
  input  logic [ADDR_W-1:0] offset,
  output logic [7:0]        past_output,
  output logic              past_valid,
  output logic              busy,
  output logic              overrun,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_req rises with we/addr/wdata and all stay stable until the
  // cycle in which mem_ack is high; the transfer completes on that clock edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]          wbuf_q, wbuf_d;
  logic [7:0]          past_output_q, past_output_d;
  logic                past_valid_q, past_valid_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   eff;
  logic [ADDR_W-1:0]   rd_idx;
  logic                skip_rd;

`ifdef TEAM_06_FILL_GUARD_EN
  logic [ADDR_W-1:0]   fill_q, fill_d;
`endif

  function automatic logic [MEM_AW-1:0] slot_addr(input logic [ADDR_W-1:0] idx);
    return BASE_ADDR + MEM_AW'(idx);
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    wbuf_d        = wbuf_q;
    past_output_d = past_output_q;
    past_valid_d  = 1'b0;
    overrun_d     = overrun_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    eff           = (offset == '0) ? ADDR_W'(1) : offset;
    rd_idx        = wr_ptr_q - eff;
`ifdef TEAM_06_FILL_GUARD_EN
    fill_d        = fill_q;
    skip_rd       = (eff > fill_q);
`else
    skip_rd       = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          wbuf_d    = save_audio;
          mem_req_d = 1'b1;
          if (skip_rd) begin
            // Not enough history yet: emit silence and go straight to the write.
            past_output_d = '0;
            past_valid_d  = 1'b1;
            mem_we_d      = 1'b1;
            mem_addr_d    = slot_addr(wr_ptr_q);
            mem_wdata_d   = save_audio;
            state_d       = ST_WR;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = slot_addr(rd_idx);
            state_d    = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (sample_tick) overrun_d = 1'b1;
        if (mem_ack) begin
          past_output_d = mem_rdata;
          past_valid_d  = 1'b1;
          mem_we_d      = 1'b1;
          mem_addr_d    = slot_addr(wr_ptr_q);
          mem_wdata_d   = wbuf_q;
          state_d       = ST_WR;
        end
      end
      ST_WR: begin
        // A tick coinciding with the write ack is still dropped.
        if (sample_tick) overrun_d = 1'b1;
        if (mem_ack) begin
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
`ifdef TEAM_06_FILL_GUARD_EN
          if (fill_q != '1) fill_d = fill_q + ADDR_W'(1);
`endif
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      wbuf_q        <= '0;
      past_output_q <= '0;
      past_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
`ifdef TEAM_06_FILL_GUARD_EN
      fill_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wbuf_q        <= wbuf_d;
      past_output_q <= past_output_d;
      past_valid_q  <= past_valid_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
`ifdef TEAM_06_FILL_GUARD_EN
      fill_q        <= fill_d;
`endif
    end
  end

  assign past_output = past_output_q;
  assign past_valid  = past_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_team_06_delay_line_ctrl.sv
// Bench for team_06_delay_line_ctrl: a byte-memory responder, a ring reference
// model feeding expected queues, and a past_output monitor.
module tb_team_06_delay_line_ctrl;
  localparam int          AW   = 13;
  localparam int          N    = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_tick = 1'b0;
  logic [7:0]    save_audio = '0;
  logic [AW-1:0] offset = '0;
  logic [7:0]    past_output;
  logic          past_valid, busy, overrun, mem_req, mem_we;
  logic [31:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_arr  [N];
  logic [7:0]  ring_ref [N];
  int          wp_ref = 0;
  int          writes_ref = 0;
  logic [7:0]  exp_past_q[$];
  logic [31:0] exp_rd_q[$];
  logic [39:0] exp_wr_q[$];
  int          max_wait = 0;
  int          wait_cnt = 0;
  bit          stray_en = 1'b0;
  logic [31:0] rel;

  team_06_delay_line_ctrl #(.ADDR_W(AW), .MEM_AW(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .save_audio(save_audio),
    .offset(offset), .past_output(past_output), .past_valid(past_valid),
    .busy(busy), .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: ring contents, write pointer and history count from the rules
  task automatic model_reset();
    wp_ref = 0;
    writes_ref = 0;
  endtask

  task automatic model_tick(input logic [7:0] s, input logic [AW-1:0] off);
    int eff, rd, fill;
    eff  = (off == 0) ? 1 : int'(off);
    rd   = (wp_ref - eff + N) % N;
    fill = (writes_ref < N - 1) ? writes_ref : N - 1;
`ifdef TEAM_06_FILL_GUARD_EN
    if (eff > fill) begin
      exp_past_q.push_back(8'h00);
    end else begin
      exp_rd_q.push_back(BASE + 32'(rd));
      exp_past_q.push_back(ring_ref[rd]);
    end
`else
    exp_rd_q.push_back(BASE + 32'(rd));
    exp_past_q.push_back(ring_ref[rd]);
`endif
    exp_wr_q.push_back({BASE + 32'(wp_ref), s});
    ring_ref[wp_ref] = s;
    wp_ref = (wp_ref + 1) % N;
    writes_ref++;
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy still 1 after 300 cycles, expected 0");
  endtask

  task automatic tick(input logic [7:0] s, input logic [AW-1:0] off, input bit use_model);
    wait_idle();
    sample_tick = 1'b1;
    save_audio  = s;
    offset      = off;
    if (use_model) model_tick(s, off);
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_off();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return AW'(1);
      2:       return AW'(N - 1);
      3:       return AW'($urandom_range(1, 16));
      default: return AW'($urandom_range(0, N - 1));
    endcase
  endfunction

  // memory responder: acks after a random wait and checks each request's address/data
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        mem_ack = 1'b1;
        rel = mem_addr - BASE;
        if (mem_we) begin
          if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: got write 0x%0h=0x%0h, expected none", mem_addr, mem_wdata);
          end else begin
            check("wr_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
          end
          mem_arr[rel[AW-1:0]] = mem_wdata;
        end else begin
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got read 0x%0h, expected none", mem_addr);
          end else begin
            check("rd_addr", {8'h00, mem_addr}, {8'h00, exp_rd_q.pop_front()});
          end
          mem_rdata = mem_arr[rel[AW-1:0]];
        end
        wait_cnt = $urandom_range(0, max_wait);
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
    end
  end

  // scoreboard monitor for past_output
  always @(negedge clk) begin
    if (past_valid) begin
      if (exp_past_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL past_unexpected: got past_output 0x%0h, expected no pulse", past_output);
      end else begin
        check("past_output", {32'h0, past_output}, {32'h0, exp_past_q.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_arr[i]  = 8'($urandom);
      ring_ref[i] = mem_arr[i];
    end

    // reset held with sample_tick high
    sample_tick = 1'b1;
    save_audio  = 8'hA5;
    offset      = AW'(3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_outputs",
            {past_output, past_valid, busy, overrun, mem_req, mem_we, mem_wdata, 21'h0},
            40'h0);
      check("reset_addr", {8'h0, mem_addr}, 40'h0);
    end
    sample_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // zero-wait timing, plus a tick on the write-ack edge being dropped
    sample_tick = 1'b1; save_audio = 8'd68; offset = AW'(1);
    model_tick(8'd68, AW'(1));
    @(negedge clk);
    sample_tick = 1'b0;
    check("req_rise", {39'h0, mem_req}, 40'h1);
`ifdef TEAM_06_FILL_GUARD_EN
    check("guard_valid_at_1", {39'h0, past_valid}, 40'h1);
    sample_tick = 1'b1; save_audio = 8'h77;
    @(negedge clk);
    sample_tick = 1'b0;
    check("guard_idle_at_2", {39'h0, busy}, 40'h0);
`else
    check("valid_low_at_1", {39'h0, past_valid}, 40'h0);
    @(negedge clk);
    check("valid_at_2", {39'h0, past_valid}, 40'h1);
    sample_tick = 1'b1; save_audio = 8'h77;
    @(negedge clk);
    sample_tick = 1'b0;
    check("idle_at_3", {39'h0, busy}, 40'h0);
`endif
    check("drop_on_wr_ack_overrun", {39'h0, overrun}, 40'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check("overrun_cleared", {39'h0, overrun}, 40'h0);

    // directed: first write lands at slot 0, basic delay, offset 0
    tick(8'd68, AW'(1), 1'b1);
    tick(8'd10, AW'(2), 1'b1);
    tick(8'd20, AW'(2), 1'b1);
    tick(8'd30, AW'(2), 1'b1);
    tick(8'd50, AW'(1), 1'b1);
    tick(8'd89, AW'(0), 1'b1);

    // random waits, stray acks and gaps
    max_wait = 3;
    stray_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      tick(8'($urandom), rand_off(), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    stray_en = 1'b0;
    max_wait = 0;
    wait_cnt = 0;

    // long zero-wait run so the write pointer wraps
    for (int t = 0; t < 8000; t++) tick(8'($urandom), rand_off(), 1'b1);
    tick(8'hC3, AW'(N - 1), 1'b1);
    wait_idle();
    check("no_overrun_after_run", {39'h0, overrun}, 40'h0);

    // stalled read with an extra tick during RD_REQ
    wait_cnt = 5;
    tick(8'h3C, AW'(1), 1'b1);
    sample_tick = 1'b1; save_audio = 8'hEE; offset = AW'(4);
    @(negedge clk);
    sample_tick = 1'b0;
    check("stall_req_held", {39'h0, mem_req}, 40'h1);
    check("stall_no_valid", {39'h0, past_valid}, 40'h0);
    wait_idle();
    check("overrun_set", {39'h0, overrun}, 40'h1);
    tick(8'h5A, AW'(1), 1'b1);
    wait_idle();
    check("overrun_sticky", {39'h0, overrun}, 40'h1);

    // reset in the middle of a stalled read
    wait_cnt = 20;
    tick(8'hAB, AW'(3), 1'b0);
    @(negedge clk);
    check("mid_rd_req", {39'h0, mem_req}, 40'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check("abort_req_low", {39'h0, mem_req}, 40'h0);
    check("abort_overrun", {39'h0, overrun}, 40'h0);
    check("abort_busy", {39'h0, busy}, 40'h0);
    check("abort_past", {32'h0, past_output}, 40'h0);

    // one write, then a look-back beyond the available history
    tick(8'd7, AW'(1), 1'b1);
    tick(8'd8, AW'(5), 1'b1);
    wait_idle();
    repeat (4) @(negedge clk);

    check("queues_drained", 40'(exp_past_q.size() + exp_rd_q.size() + exp_wr_q.size()), 40'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
